// File: rtl/gp0_reg_slave_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gp0_reg_slave_if : AXI4 channel bundle between the GP0 master and the
//                    board-I/O register slave.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface gp0_reg_slave_if;
  logic [11:0] awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [11:0] bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  logic [11:0] arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [11:0] rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awid, awaddr, awlen, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface
`default_nettype wire

// File: rtl/gp0_reg_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gp0_reg_slave : AXI4 slave holding the LED / input / scratch / ID registers.
// Revision: 1.0
// ---------------------------------------------------------------------------
module gp0_reg_slave #(
  parameter logic [31:0] ID_VALUE  = 32'h1B11_0001,
  parameter logic [9:0]  LED_RESET = 10'h000
) (
  input  logic             sysclk,
  input  logic             reset,
  gp0_reg_slave_if.slave   s,
  output logic [3:0]       leds,
  output logic [2:0]       led4,
  output logic [2:0]       led5,
  input  logic [1:0]       switches,
  input  logic [3:0]       btns
);

  localparam logic [1:0] WORD_LED     = 2'd0;
  localparam logic [1:0] WORD_INPUT   = 2'd1;
  localparam logic [1:0] WORD_SCRATCH = 2'd2;
  localparam logic [1:0] BURST_FIXED  = 2'b00;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

  // Register bank
  logic [9:0]  led_q, led_d;
  logic [31:0] scratch_q, scratch_d;
  logic [5:0]  sync1_q, sync2_q;

  // Write channel state
  wstate_e     wstate_q, wstate_d;
  logic [11:0] bid_q, bid_d;
  logic [7:0]  awlen_q, awlen_d;
  logic [1:0]  awburst_q, awburst_d;
  logic [1:0]  wword_q, wword_d;
  logic [8:0]  wbeat_q, wbeat_d;
  logic        werr_q, werr_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        w_commit;

  // Read channel state
  rstate_e     rstate_q, rstate_d;
  logic [11:0] rid_q, rid_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [1:0]  arburst_q, arburst_d;
  logic [1:0]  rword_q, rword_d;
  logic [7:0]  rbeat_q, rbeat_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rlast_q, rlast_d;

  logic        unused_addr_bits;

  function automatic logic [1:0] next_word(input logic [1:0] word, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? word : word + 2'd1;
  endfunction

  function automatic logic [31:0] read_word(input logic [1:0]  word,
                                            input logic [9:0]  led,
                                            input logic [5:0]  inp,
                                            input logic [31:0] scratch);
    logic [31:0] data;
    case (word)
      WORD_LED:     data = {22'b0, led};
      WORD_INPUT:   data = {26'b0, inp};
      WORD_SCRATCH: data = scratch;
      default:      data = ID_VALUE;
    endcase
    return data;
  endfunction

  // ---------------------------------------------------------------- write FSM
  always_ff @(posedge sysclk) begin
    if (reset) begin
      wstate_q  <= W_IDLE;
      bid_q     <= 12'h000;
      awlen_q   <= 8'h00;
      awburst_q <= 2'b00;
      wword_q   <= 2'd0;
      wbeat_q   <= 9'd0;
      werr_q    <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      wstate_q  <= wstate_d;
      bid_q     <= bid_d;
      awlen_q   <= awlen_d;
      awburst_q <= awburst_d;
      wword_q   <= wword_d;
      wbeat_q   <= wbeat_d;
      werr_q    <= werr_d;
      bresp_q   <= bresp_d;
    end
  end

  always_comb begin
    wstate_d  = wstate_q;
    bid_d     = bid_q;
    awlen_d   = awlen_q;
    awburst_d = awburst_q;
    wword_d   = wword_q;
    wbeat_d   = wbeat_q;
    werr_d    = werr_q;
    bresp_d   = bresp_q;
    w_commit  = 1'b0;
    s.awready = !reset && (wstate_q == W_IDLE);
    s.wready  = !reset && (wstate_q == W_DATA);
    s.bvalid  = !reset && (wstate_q == W_RESP);

    case (wstate_q)
      W_IDLE: begin
        if (s.awvalid) begin
          wstate_d  = W_DATA;
          bid_d     = s.awid;
          awlen_d   = s.awlen;
          awburst_d = s.awburst;
          wword_d   = s.awaddr[3:2];
          wbeat_d   = 9'd0;
          werr_d    = 1'b0;
        end
      end
      W_DATA: begin
        if (s.wvalid) begin
          // Beats beyond awlen+1 are swallowed so the master can still finish on wlast
          w_commit = (wbeat_q <= {1'b0, awlen_q});
          if (w_commit) begin
            wbeat_d = wbeat_q + 9'd1;
            wword_d = next_word(wword_q, awburst_q);
          end
          if (s.wlast) begin
            wstate_d = W_RESP;
            bresp_d  = (werr_q || (wbeat_q != {1'b0, awlen_q})) ? RESP_SLVERR : RESP_OKAY;
          end else if (wbeat_q == {1'b0, awlen_q}) begin
            werr_d = 1'b1;
          end
        end
      end
      W_RESP: begin
        if (s.bready) begin
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  assign s.bid   = bid_q;
  assign s.bresp = bresp_q;

  // ------------------------------------------------------------ register bank
  always_comb begin
    led_d     = led_q;
    scratch_d = scratch_q;
    if (w_commit) begin
      case (wword_q)
        WORD_LED: begin
          if (s.wstrb[0]) led_d[7:0] = s.wdata[7:0];
          if (s.wstrb[1]) led_d[9:8] = s.wdata[9:8];
        end
        WORD_SCRATCH: begin
          for (int i = 0; i < 4; i++) begin
            if (s.wstrb[i]) scratch_d[8*i +: 8] = s.wdata[8*i +: 8];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      led_q     <= LED_RESET;
      scratch_q <= 32'h0000_0000;
      sync1_q   <= 6'b0;
      sync2_q   <= 6'b0;
    end else begin
      led_q     <= led_d;
      scratch_q <= scratch_d;
      sync1_q   <= {btns, switches};
      sync2_q   <= sync1_q;
    end
  end

  assign leds = led_q[3:0];
  assign led4 = led_q[6:4];
  assign led5 = led_q[9:7];

  // ----------------------------------------------------------------- read FSM
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rstate_q  <= R_IDLE;
      rid_q     <= 12'h000;
      arlen_q   <= 8'h00;
      arburst_q <= 2'b00;
      rword_q   <= 2'd0;
      rbeat_q   <= 8'h00;
      rdata_q   <= 32'h0000_0000;
      rlast_q   <= 1'b0;
    end else begin
      rstate_q  <= rstate_d;
      rid_q     <= rid_d;
      arlen_q   <= arlen_d;
      arburst_q <= arburst_d;
      rword_q   <= rword_d;
      rbeat_q   <= rbeat_d;
      rdata_q   <= rdata_d;
      rlast_q   <= rlast_d;
    end
  end

  always_comb begin
    rstate_d  = rstate_q;
    rid_d     = rid_q;
    arlen_d   = arlen_q;
    arburst_d = arburst_q;
    rword_d   = rword_q;
    rbeat_d   = rbeat_q;
    rdata_d   = rdata_q;
    rlast_d   = rlast_q;
    s.arready = !reset && (rstate_q == R_IDLE);
    s.rvalid  = !reset && (rstate_q == R_DATA);

    case (rstate_q)
      R_IDLE: begin
        if (s.arvalid) begin
          rstate_d  = R_DATA;
          rid_d     = s.arid;
          arlen_d   = s.arlen;
          arburst_d = s.arburst;
          rbeat_d   = 8'h00;
          rdata_d   = read_word(s.araddr[3:2], led_q, sync2_q, scratch_q);
          rlast_d   = (s.arlen == 8'h00);
          // rword tracks the word of the next beat to be fetched
          rword_d   = next_word(s.araddr[3:2], s.arburst);
        end
      end
      R_DATA: begin
        if (s.rready) begin
          if (rlast_q) begin
            rstate_d = R_IDLE;
          end else begin
            rdata_d = read_word(rword_q, led_q, sync2_q, scratch_q);
            rbeat_d = rbeat_q + 8'd1;
            rlast_d = ((rbeat_q + 8'd1) == arlen_q);
            rword_d = next_word(rword_q, arburst_q);
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  assign s.rid   = rid_q;
  assign s.rdata = rdata_q;
  assign s.rresp = RESP_OKAY;
  assign s.rlast = rlast_q;

  assign unused_addr_bits = ^{s.awaddr[31:4], s.awaddr[1:0], s.araddr[31:4], s.araddr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_gp0_reg_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gp0_reg_slave : directed self-checking bench for gp0_reg_slave.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_gp0_reg_slave;

  localparam logic [31:0] ID_VALUE = 32'h1B11_0001;

  logic       sysclk = 1'b0;
  logic       reset;
  logic [3:0] leds;
  logic [2:0] led4;
  logic [2:0] led5;
  logic [1:0] switches;
  logic [3:0] btns;

  int total = 0;
  int bad   = 0;

  gp0_reg_slave_if bus ();

  gp0_reg_slave #(
    .ID_VALUE  (ID_VALUE),
    .LED_RESET (10'h000)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .s        (bus),
    .leds     (leds),
    .led4     (led4),
    .led5     (led5),
    .switches (switches),
    .btns     (btns)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  // All tasks start and end on a falling edge.
  task automatic aw(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                    input logic [11:0] id);
    int n = 0;
    bus.awaddr = addr; bus.awlen = len; bus.awburst = burst; bus.awid = id; bus.awvalid = 1'b1;
    while (!bus.awready && n < 20) begin @(negedge sysclk); n++; end
    if (n >= 20) timeout("aw_wait");
    @(negedge sysclk);
    bus.awvalid = 1'b0;
    check("wready_after_aw", {31'b0, bus.wready}, 32'd1);
    check("awready_busy", {31'b0, bus.awready}, 32'd0);
  endtask

  task automatic wbeat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
    while (!bus.wready && n < 20) begin @(negedge sysclk); n++; end
    if (n >= 20) timeout("w_wait");
    @(negedge sysclk);
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic bresp(input string tag, input logic [1:0] exp_resp, input logic [11:0] exp_id);
    check({tag, "_bvalid"}, {31'b0, bus.bvalid}, 32'd1);
    check({tag, "_bresp"}, {30'b0, bus.bresp}, {30'b0, exp_resp});
    check({tag, "_bid"}, {20'b0, bus.bid}, {20'b0, exp_id});
    bus.bready = 1'b1;
    @(negedge sysclk);
    bus.bready = 1'b0;
    check({tag, "_bvalid_clr"}, {31'b0, bus.bvalid}, 32'd0);
  endtask

  task automatic ar(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                    input logic [11:0] id);
    int n = 0;
    bus.araddr = addr; bus.arlen = len; bus.arburst = burst; bus.arid = id; bus.arvalid = 1'b1;
    while (!bus.arready && n < 20) begin @(negedge sysclk); n++; end
    if (n >= 20) timeout("ar_wait");
    @(negedge sysclk);
    bus.arvalid = 1'b0;
  endtask

  task automatic rbeat(input string tag, input logic [31:0] exp_data, input logic exp_last);
    check({tag, "_rvalid"}, {31'b0, bus.rvalid}, 32'd1);
    check({tag, "_rdata"}, bus.rdata, exp_data);
    check({tag, "_rlast"}, {31'b0, bus.rlast}, {31'b0, exp_last});
    bus.rready = 1'b1;
    @(negedge sysclk);
    bus.rready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; switches = 2'b00; btns = 4'b0000;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    repeat (3) @(negedge sysclk);

    // Reset state: no ready/valid while reset is high
    check("rst_awready", {31'b0, bus.awready}, 32'd0);
    check("rst_arready", {31'b0, bus.arready}, 32'd0);
    check("rst_wready", {31'b0, bus.wready}, 32'd0);
    check("rst_bvalid", {31'b0, bus.bvalid}, 32'd0);
    check("rst_rvalid", {31'b0, bus.rvalid}, 32'd0);
    reset = 1'b0;
    @(negedge sysclk);
    check("rst_leds", {22'b0, led5, led4, leds}, 32'd0);
    check("rst_bresp", {30'b0, bus.bresp}, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_rlast", {31'b0, bus.rlast}, 32'd0);
    check("idle_awready", {31'b0, bus.awready}, 32'd1);
    check("idle_arready", {31'b0, bus.arready}, 32'd1);

    // Single LED write
    aw(32'h0, 8'd0, 2'b01, 12'h123);
    wbeat(32'h0000_03FF, 4'hF, 1'b1);
    bresp("led_wr", 2'b00, 12'h123);
    check("leds_F", {28'b0, leds}, 32'hF);
    check("led4_7", {29'b0, led4}, 32'h7);
    check("led5_7", {29'b0, led5}, 32'h7);

    // ID read
    ar(32'hC, 8'd0, 2'b01, 12'hABC);
    check("id_rid", {20'b0, bus.rid}, 32'hABC);
    check("id_rresp", {30'b0, bus.rresp}, 32'd0);
    rbeat("id_rd", ID_VALUE, 1'b1);

    // INCR write from word 2: SCRATCH=1, ID dropped, LED=3, INPUT dropped
    aw(32'h8, 8'd3, 2'b01, 12'h055);
    wbeat(32'd1, 4'hF, 1'b0);
    wbeat(32'd2, 4'hF, 1'b0);
    wbeat(32'd3, 4'hF, 1'b0);
    wbeat(32'd4, 4'hF, 1'b1);
    bresp("incr_wr", 2'b00, 12'h055);
    check("incr_leds", {22'b0, led5, led4, leds}, 32'h3);

    // INCR read of the same four words
    ar(32'h8, 8'd3, 2'b01, 12'h001);
    rbeat("incr_rd0", 32'd1, 1'b0);
    rbeat("incr_rd1", ID_VALUE, 1'b0);
    rbeat("incr_rd2", 32'd3, 1'b0);
    rbeat("incr_rd3", 32'd0, 1'b1);
    check("incr_rd_done", {31'b0, bus.rvalid}, 32'd0);

    // Byte-strobed write over a cleared SCRATCH
    aw(32'h8, 8'd0, 2'b01, 12'h002);
    wbeat(32'h0, 4'hF, 1'b1);
    bresp("scr_clr", 2'b00, 12'h002);
    aw(32'h8, 8'd0, 2'b01, 12'h003);
    wbeat(32'hFFFF_FFFF, 4'b0010, 1'b1);
    bresp("scr_byte", 2'b00, 12'h003);

    // Early wlast -> SLVERR (target is the read-only ID word)
    aw(32'hC, 8'd1, 2'b01, 12'h004);
    wbeat(32'h1234_5678, 4'hF, 1'b1);
    bresp("early_last", 2'b10, 12'h004);

    // FIXED read of SCRATCH with rready withheld for 5 cycles
    ar(32'h8, 8'd1, 2'b00, 12'h005);
    repeat (5) begin
      check("stall_rvalid", {31'b0, bus.rvalid}, 32'd1);
      check("stall_rdata", bus.rdata, 32'h0000_FF00);
      @(negedge sysclk);
    end
    rbeat("fixed_rd0", 32'h0000_FF00, 1'b0);
    rbeat("fixed_rd1", 32'h0000_FF00, 1'b1);

    // Missing wlast at beat awlen+1: first beat commits, extra beat dropped
    aw(32'h0, 8'd0, 2'b00, 12'h006);
    wbeat(32'd5, 4'hF, 1'b0);
    check("no_last_bvalid", {31'b0, bus.bvalid}, 32'd0);
    wbeat(32'd7, 4'hF, 1'b1);
    bresp("no_last", 2'b10, 12'h006);
    check("no_last_leds", {22'b0, led5, led4, leds}, 32'd5);

    // Synchronised inputs: {btns, switches} = 0101_10
    switches = 2'b10; btns = 4'b0101;
    repeat (3) @(negedge sysclk);
    ar(32'h4, 8'd0, 2'b01, 12'h007);
    rbeat("input_rd", 32'h16, 1'b1);

    // Reset in the middle of a read burst
    ar(32'h0, 8'd3, 2'b01, 12'h008);
    rbeat("abort_rd0", 32'd5, 1'b0);
    reset = 1'b1;
    @(negedge sysclk);
    check("abort_rvalid", {31'b0, bus.rvalid}, 32'd0);
    reset = 1'b0;
    @(negedge sysclk);
    check("abort_rvalid_after", {31'b0, bus.rvalid}, 32'd0);
    check("abort_arready", {31'b0, bus.arready}, 32'd1);
    check("abort_leds", {22'b0, led5, led4, leds}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
